// File: rtl/mul_div_sequencer_if.sv
// Bundles the request/response handshake and the shared-ALU connection of the
// multiply/divide sequencer. The sequencer is the slave; requester + ALU side is the master.
interface mul_div_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] leftOperand;
    logic [31:0] rightOperand;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        divideByZero;
    logic [2:0]  aluOperation;
    logic [31:0] aluLeftOperand;
    logic [31:0] aluRightOperand;
    logic        aluSignedComparison;
    logic [2:0]  aluComparisonOperation;
    logic [31:0] aluResult;
    logic        aluComparisonResult;

    modport master (
        output start, op, leftOperand, rightOperand, aluResult, aluComparisonResult,
        input  busy, done, result, divideByZero, aluOperation, aluLeftOperand,
               aluRightOperand, aluSignedComparison, aluComparisonOperation
    );

    modport slave (
        input  start, op, leftOperand, rightOperand, aluResult, aluComparisonResult,
        output busy, done, result, divideByZero, aluOperation, aluLeftOperand,
               aluRightOperand, aluSignedComparison, aluComparisonOperation
    );
endinterface

// File: rtl/mul_div_sequencer.sv
// 32-bit shift-add multiplier and restoring divider that borrows an external ALU
// for every add/subtract; signed division is done on magnitudes and fixed up at the end.
module mul_div_sequencer (
    input  logic              clk,
    input  logic              reset,
    mul_div_sequencer_if.slave bus
);
    localparam logic [2:0] ALU_OPERATION_ADD            = 3'd0;
    localparam logic [2:0] ALU_OPERATION_SUB            = 3'd1;
    localparam logic [2:0] ALU_COMPARISON_GREATER_EQUAL = 3'd5;

    localparam logic [2:0] OP_MUL  = 3'd0;
    localparam logic [2:0] OP_MULU = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_DIVU = 3'd3;
    localparam logic [2:0] OP_REM  = 3'd4;
    localparam logic [2:0] OP_REMU = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NEG_L = 3'd1,
        NEG_R = 3'd2,
        ITER  = 3'd3,
        FIX   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state;
    state_t      stateNext;

    logic [2:0]  opReg;
    logic [31:0] leftReg;     // multiplicand, then dividend/quotient
    logic [31:0] rightReg;    // multiplier, then divisor
    logic [31:0] accReg;
    logic [31:0] remReg;
    logic [31:0] fixReg;
    logic [31:0] resultReg;
    logic [4:0]  count;
    logic        signL;
    logic        signR;
    logic        zeroDiv;
    logic        doneReg;
    logic        divideByZeroReg;

    logic [2:0]  aluOp;
    logic [31:0] aluL;
    logic [31:0] aluR;
    logic [31:0] shiftedRem;
    logic [31:0] fixSource;
    logic        negateFix;
    logic        takeSub;

    function automatic logic isDivide(input logic [2:0] o);
        return (o == OP_DIV) || (o == OP_DIVU) || (o == OP_REM) || (o == OP_REMU);
    endfunction

    function automatic logic isSignedDivide(input logic [2:0] o);
        return (o == OP_DIV) || (o == OP_REM);
    endfunction

    function automatic logic isRemainder(input logic [2:0] o);
        return (o == OP_REM) || (o == OP_REMU);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        aluOp      = ALU_OPERATION_ADD;
        aluL       = 32'd0;
        aluR       = 32'd0;
        shiftedRem = {remReg[30:0], leftReg[31]};
        fixSource  = accReg;
        negateFix  = 1'b0;

        if (isDivide(opReg)) begin
            fixSource = isRemainder(opReg) ? remReg : leftReg;
        end
        // Remainder takes the dividend's sign; quotient is negative when signs differ.
        if (isSignedDivide(opReg)) begin
            negateFix = isRemainder(opReg) ? signL : (signL ^ signR);
        end

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (isDivide(bus.op) && (bus.rightOperand == 32'd0)) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = NEG_L;
                    end
                end
            end
            NEG_L: begin
                if (signL) begin
                    aluOp = ALU_OPERATION_SUB;
                    aluR  = leftReg;
                end
                stateNext = NEG_R;
            end
            NEG_R: begin
                if (signR) begin
                    aluOp = ALU_OPERATION_SUB;
                    aluR  = rightReg;
                end
                stateNext = ITER;
            end
            ITER: begin
                if (isDivide(opReg)) begin
                    aluOp = ALU_OPERATION_SUB;
                    aluL  = shiftedRem;
                    aluR  = rightReg;
                end else begin
                    aluOp = ALU_OPERATION_ADD;
                    aluL  = accReg;
                    aluR  = leftReg;
                end
                if (count == 5'd31) begin
                    stateNext = FIX;
                end
            end
            FIX: begin
                if (negateFix) begin
                    aluOp = ALU_OPERATION_SUB;
                    aluR  = fixSource;
                end
                stateNext = DONE;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // A set rem[31] means the shifted partial remainder is already >= 2^32 > divisor.
    assign takeSub = remReg[31] | bus.aluComparisonResult;

    always_ff @(posedge clk) begin
        if (reset) begin
            opReg           <= 3'd0;
            leftReg         <= 32'd0;
            rightReg        <= 32'd0;
            accReg          <= 32'd0;
            remReg          <= 32'd0;
            fixReg          <= 32'd0;
            resultReg       <= 32'd0;
            count           <= 5'd0;
            signL           <= 1'b0;
            signR           <= 1'b0;
            zeroDiv         <= 1'b0;
            doneReg         <= 1'b0;
            divideByZeroReg <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        opReg    <= bus.op;
                        leftReg  <= bus.leftOperand;
                        rightReg <= bus.rightOperand;
                        signL    <= isSignedDivide(bus.op) & bus.leftOperand[31];
                        signR    <= isSignedDivide(bus.op) & bus.rightOperand[31];
                        zeroDiv  <= isDivide(bus.op) && (bus.rightOperand == 32'd0);
                        fixReg   <= 32'd0;
                    end
                end
                NEG_L: begin
                    if (signL) begin
                        leftReg <= bus.aluResult;
                    end
                end
                NEG_R: begin
                    if (signR) begin
                        rightReg <= bus.aluResult;
                    end
                    count  <= 5'd0;
                    accReg <= 32'd0;
                    remReg <= 32'd0;
                end
                ITER: begin
                    count <= count + 5'd1;
                    if (isDivide(opReg)) begin
                        leftReg <= {leftReg[30:0], takeSub};
                        remReg  <= takeSub ? bus.aluResult : shiftedRem;
                    end else begin
                        if (rightReg[0]) begin
                            accReg <= bus.aluResult;
                        end
                        leftReg  <= {leftReg[30:0], 1'b0};
                        rightReg <= {1'b0, rightReg[31:1]};
                    end
                end
                FIX: begin
                    fixReg <= negateFix ? bus.aluResult : fixSource;
                end
                DONE: begin
                    doneReg         <= 1'b1;
                    resultReg       <= fixReg;
                    divideByZeroReg <= zeroDiv;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy                   = (state != IDLE);
    assign bus.done                   = doneReg;
    assign bus.result                 = resultReg;
    assign bus.divideByZero           = divideByZeroReg;
    assign bus.aluOperation           = aluOp;
    assign bus.aluLeftOperand         = aluL;
    assign bus.aluRightOperand        = aluR;
    assign bus.aluSignedComparison    = 1'b0;
    assign bus.aluComparisonOperation = ALU_COMPARISON_GREATER_EQUAL;
endmodule
